pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges stall requests
//  from ID (load-use), EX (multi-cycle mul/div) and MEM (bus wait) into one stall
//  vector driving PC and every inter-stage buffer, including the MEM/WB buffer.
//  Sequences multi-cycle EX ops with an internal countdown, one-cycle exception
//  flushes, and a MEM-wait watchdog.
// PARAMETERS
//  CNT_WIDTH    6    width of ex_op_cycles and the EX countdown
//  MEM_TIMEOUT  255  consecutive mem_stall_req cycles before mem_timeout fires
//  PC_WIDTH     32   width of exc_handler_addr / flush_pc
// PORTS
//  clock             in   1          clock, rising edge
//  reset             in   1          synchronous, active-high
//  id_stall_req      in   1          ID needs a hold (load-use hazard)
//  ex_op_start       in   1          multi-cycle op entering EX this cycle
//  ex_op_cycles      in   CNT_WIDTH  number of stall cycles for that op
//  mem_stall_req     in   1          MEM waiting on data bus
//  exc_valid         in   1          exception committed in MEM
//  exc_handler_addr  in   PC_WIDTH   handler PC for exc_valid
//  stall             out  6          [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB
//  flush             out  1          clear all inter-stage buffers this cycle
//  flush_pc          out  PC_WIDTH   PC to load while flush=1
//  ex_op_done        out  1          one-cycle pulse: multi-cycle op result valid
//  mem_timeout       out  1          one-cycle pulse: MEM wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//  - Reset: state RUN, cnt=0, wcnt=0; stall=6'b000000, flush=0, flush_pc=0,
//    ex_op_done=0, mem_timeout=0. Reset aborts any EX countdown or pending flush.
//  - States: RUN, EX_BUSY, FLUSH. stall is combinational from state + requests;
//    flush, flush_pc, ex_op_done, mem_timeout are registered.
//  - Stall codes: id 6'b000111, ex 6'b001111, mem 6'b011111; the widest active
//    request wins (mem > ex > id). No request -> 6'b000000.
//  - EX request active when (RUN & ex_op_start & ex_op_cycles!=0) or EX_BUSY.
//  - RUN: ex_op_start with N=ex_op_cycles>=1 at cycle t -> stall EX code in cycles
//    t..t+N-1, state EX_BUSY, cnt=N-1 at t+1; ex_op_done=1 in cycle t+N only,
//    stall released that cycle. N=0 -> no stall, ex_op_done=1 in cycle t+1.
//  - EX_BUSY: cnt decrements every cycle even while MEM stalls; cnt==0 -> RUN
//    with done pulse. ex_op_start ignored while EX_BUSY.
//  - exc_valid sampled in any state (priority over all): next cycle state FLUSH,
//    flush=1, flush_pc=exc_handler_addr, stall=0; EX countdown aborted with no
//    done pulse. FLUSH lasts exactly one cycle, then RUN. exc_valid during FLUSH
//    ignored. In the exc_valid cycle itself stall follows normal rules.
//  - Watchdog: wcnt counts consecutive cycles with mem_stall_req=1, saturating at
//    MEM_TIMEOUT; mem_timeout=1 for the one cycle after wcnt first reaches
//    MEM_TIMEOUT; no re-fire until mem_stall_req drops (wcnt->0). FLUSH clears wcnt.
//  - flush_pc holds its last value when flush=0.
// TESTING
//  1 Reset mid-EX_BUSY (N=10, reset at cycle 4) -> next cycle stall=0, no done pulse.
//  2 ex_op_start, ex_op_cycles=3 at t -> stall=001111 at t,t+1,t+2; ex_op_done=1 at
//    t+3 only; stall=000000 at t+3.
//  3 id_stall_req=1 alone -> stall=000111; with mem_stall_req=1 too -> 011111.
//  4 EX_BUSY (N=8) + exc_valid, handler 0x0000_0180 at t -> t+1: flush=1,
//    flush_pc=0x180, stall=0; t+2: RUN, flush=0, ex_op_done never pulses.
//  5 MEM_TIMEOUT=4, mem_stall_req held 10 cycles -> exactly one mem_timeout pulse,
//    cycle after 4th wait cycle; drop 1 cycle, hold 4 more -> second pulse.
//  6 ex_op_cycles=0 start -> no stall, ex_op_done at t+1; mem stall during N=5 op
//    -> done still at t+5 with stall=011111 while mem_stall_req=1.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: merges ID/EX/MEM stall requests, times multi-cycle
// EX operations, turns a committed exception into a one-cycle flush and watches MEM waits.
module pipeline_ctrl #(
  parameter int CNT_WIDTH   = 6,
  parameter int MEM_TIMEOUT = 255,
  parameter int PC_WIDTH    = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 id_stall_req,
  input  logic                 ex_op_start,
  input  logic [CNT_WIDTH-1:0] ex_op_cycles,
  input  logic                 mem_stall_req,
  input  logic                 exc_valid,
  input  logic [PC_WIDTH-1:0]  exc_handler_addr,
  output logic [5:0]           stall,
  output logic                 flush,
  output logic [PC_WIDTH-1:0]  flush_pc,
  output logic                 ex_op_done,
  output logic                 mem_timeout
);

  localparam int WCNT_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = WCNT_WIDTH'(MEM_TIMEOUT);
  localparam logic [WCNT_WIDTH-1:0] WCNT_ARM = WCNT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [5:0] STALL_ID  = 6'b000111;
  localparam logic [5:0] STALL_EX  = 6'b001111;
  localparam logic [5:0] STALL_MEM = 6'b011111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    EX_BUSY = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [WCNT_WIDTH-1:0] wcnt_q;
  logic                  flush_q;
  logic [PC_WIDTH-1:0]   flush_pc_q;
  logic                  done_q;
  logic                  timeout_q;
  logic                  ex_req;

  // A zero-length op never holds the pipe; it only produces a done pulse.
  always_comb begin
    ex_req = ((state_q == RUN) && ex_op_start && (ex_op_cycles != '0))
             || (state_q == EX_BUSY);
    stall  = 6'b000000;
    if (state_q != FLUSH) begin
      if (mem_stall_req)     stall = STALL_MEM;
      else if (ex_req)       stall = STALL_EX;
      else if (id_stall_req) stall = STALL_ID;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      flush_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;

      // Fires only on the step into saturation, so a long wait yields one pulse.
      if ((state_q == FLUSH) || !mem_stall_req) begin
        wcnt_q <= '0;
      end else if (wcnt_q != WCNT_MAX) begin
        wcnt_q <= wcnt_q + WCNT_WIDTH'(1);
        if (wcnt_q == WCNT_ARM) timeout_q <= 1'b1;
      end

      if (exc_valid && (state_q != FLUSH)) begin
        state_q    <= FLUSH;
        flush_q    <= 1'b1;
        flush_pc_q <= exc_handler_addr;
        cnt_q      <= '0;
      end else begin
        case (state_q)
          RUN: begin
            if (ex_op_start) begin
              // N stall cycles: the start cycle plus N-1 cycles in EX_BUSY.
              if (ex_op_cycles > CNT_ONE) begin
                state_q <= EX_BUSY;
                cnt_q   <= ex_op_cycles - CNT_ONE;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          EX_BUSY: begin
            if (cnt_q <= CNT_ONE) begin
              state_q <= RUN;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign flush       = flush_q;
  assign flush_pc    = flush_pc_q;
  assign ex_op_done  = done_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each driven cycle queues the outputs expected
// in that cycle; a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

  localparam logic [5:0] S_ID  = 6'b000111;
  localparam logic [5:0] S_EX  = 6'b001111;
  localparam logic [5:0] S_MEM = 6'b011111;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_stall_req;
  logic        ex_op_start;
  logic [5:0]  ex_op_cycles;
  logic        mem_stall_req;
  logic        exc_valid;
  logic [31:0] exc_handler_addr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        ex_op_done;
  logic        mem_timeout;

  pipeline_ctrl #(
    .CNT_WIDTH   (6),
    .MEM_TIMEOUT (4),
    .PC_WIDTH    (32)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .id_stall_req     (id_stall_req),
    .ex_op_start      (ex_op_start),
    .ex_op_cycles     (ex_op_cycles),
    .mem_stall_req    (mem_stall_req),
    .exc_valid        (exc_valid),
    .exc_handler_addr (exc_handler_addr),
    .stall            (stall),
    .flush            (flush),
    .flush_pc         (flush_pc),
    .ex_op_done       (ex_op_done),
    .mem_timeout      (mem_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] fpc;
    logic        done;
    logic        to;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  logic [31:0] efpc = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input bit rst, input bit id, input bit st,
                       input int n, input bit mem, input bit exc, input logic [31:0] addr,
                       input logic [5:0] est, input bit efl, input bit edn, input bit eto);
    reset            = rst;
    id_stall_req     = id;
    ex_op_start      = st;
    ex_op_cycles     = 6'(n);
    mem_stall_req    = mem;
    exc_valid        = exc;
    exc_handler_addr = addr;
    sb.push_back('{tag, est, efl, efpc, edn, eto});
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      check_eq({cur.tag, ".stall"}, 32'(stall), 32'(cur.stall));
      check_eq({cur.tag, ".flush"}, 32'(flush), 32'(cur.flush));
      check_eq({cur.tag, ".flush_pc"}, flush_pc, cur.fpc);
      check_eq({cur.tag, ".done"}, 32'(ex_op_done), 32'(cur.done));
      check_eq({cur.tag, ".timeout"}, 32'(mem_timeout), 32'(cur.to));
      $display("txn %-10s stall=%b flush=%b pc=%h done=%b to=%b", cur.tag,
               stall, flush, flush_pc, ex_op_done, mem_timeout);
    end
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset = 1'b1; id_stall_req = 1'b0; ex_op_start = 1'b0; ex_op_cycles = '0;
    mem_stall_req = 1'b0; exc_valid = 1'b0; exc_handler_addr = '0;
    @(posedge clock);
    #1;
    drive("rst", 1, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);
    drive("rst", 1, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);

    // 3-cycle op: stall t..t+2, done and release at t+3
    drive("t2_start", 0, 0, 1, 3, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t2_busy",  0, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t2_busy",  0, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t2_done",  0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 1, 0);
    drive("t2_idle",  0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);

    // Priority among requests
    drive("t3_id",     0, 1, 0, 0, 0, 0, 0, S_ID,  0, 0, 0);
    drive("t3_idmem",  0, 1, 0, 0, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t3_mem",    0, 0, 0, 0, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t3_idex",   0, 1, 1, 2, 0, 0, 0, S_EX,  0, 0, 0);
    drive("t3_idbusy", 0, 1, 0, 0, 0, 0, 0, S_EX,  0, 0, 0);
    drive("t3_iddone", 0, 1, 0, 0, 0, 0, 0, S_ID,  0, 1, 0);
    drive("t3_idle",   0, 0, 0, 0, 0, 0, 0, 6'b0,  0, 0, 0);

    // Exception during EX_BUSY aborts the op; second exc in FLUSH ignored
    drive("t4_start", 0, 0, 1, 8, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t4_busy",  0, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t4_exc",   0, 0, 0, 0, 0, 1, 32'h0000_0180, S_EX, 0, 0, 0);
    efpc = 32'h0000_0180;
    drive("t4_flush", 0, 0, 0, 0, 0, 1, 32'h0000_0200, 6'b0, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      drive("t4_after", 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);

    // Reset in the 4th cycle of a 10-cycle op
    drive("t1_start", 0, 0, 1, 10, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t1_busy",  0, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t1_busy",  0, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    drive("t1_rst",   1, 0, 0, 0, 0, 0, 0, S_EX, 0, 0, 0);
    efpc = 32'h0;
    for (int i = 0; i < 10; i++)
      drive("t1_after", 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);

    // Zero-length op, then a 5-cycle op overlapped by MEM wait
    drive("t6_n0",    0, 0, 1, 0, 0, 0, 0, 6'b0, 0, 0, 0);
    drive("t6_n0dn",  0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 1, 0);
    drive("t6_idle",  0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);
    drive("t6_start", 0, 0, 1, 5, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t6_mem",   0, 0, 0, 0, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t6_mem",   0, 0, 0, 0, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t6_busy",  0, 0, 0, 0, 0, 0, 0, S_EX,  0, 0, 0);
    drive("t6_busy",  0, 0, 0, 0, 0, 0, 0, S_EX,  0, 0, 0);
    drive("t6_done",  0, 0, 0, 0, 0, 0, 0, 6'b0,  0, 1, 0);
    drive("t6_idle",  0, 0, 0, 0, 0, 0, 0, 6'b0,  0, 0, 0);

    // Watchdog with MEM_TIMEOUT=4: pulse in the cycle after the 4th wait cycle
    for (int i = 1; i <= 10; i++)
      drive("t5_hold", 0, 0, 0, 0, 1, 0, 0, S_MEM, 0, 0, (i == 5));
    drive("t5_drop", 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      drive("t5_hold2", 0, 0, 0, 0, 1, 0, 0, S_MEM, 0, 0, 0);
    drive("t5_pulse", 0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 1);
    drive("t5_idle",  0, 0, 0, 0, 0, 0, 0, 6'b0, 0, 0, 0);

    @(negedge clock);
    #1;
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
